// File: rtl/lbp_pkg.sv
// Shared geometry, FSM state type and border helper for the LBP image server.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int AW     = 14;
    localparam int DW     = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NINNER = (IMG_W - 2) * (IMG_H - 2);
    localparam int COLW   = $clog2(IMG_W);
    localparam int ROWW   = AW - COLW;

    typedef enum logic [1:0] {LOAD, SERVE, DUMP, DONE} state_t;

    // The column test against all-ones relies on IMG_W being a power of two.
    function automatic logic is_border(input logic [AW-1:0] addr);
        logic [ROWW-1:0] row;
        logic [COLW-1:0] col;
        row = addr[AW-1:COLW];
        col = addr[COLW-1:0];
        return (row == '0) || (row == ROWW'(IMG_H - 1)) || (col == '0) || (col == '1);
    endfunction

endpackage

// File: rtl/lbp_dpram.sv
// Generic DW x DEPTH RAM: synchronous write, one asynchronous read port and
// one registered read port with an enable.
module lbp_dpram #(
    parameter int DW    = 8,
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] araddr,
    output logic [DW-1:0] ardata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array itself is never reset so it maps onto RAM macros; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ardata = mem[araddr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lbp_image_server.sv
// Memory-side responder for the LBP engine: loads a gray image from the host,
// serves engine reads, captures LBP writes and streams the result image back.
import lbp_pkg::*;

module lbp_image_server (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          dump_valid,
    output logic [DW-1:0] dump_data,
    input  logic          dump_ready,
    output logic          dump_last,
    output logic          err
);

    state_t        state, state_nx;
    logic [AW-1:0] ld_cnt;
    logic [AW-1:0] dump_addr;
    logic [AW:0]   wr_cnt, wr_cnt_nx;
    logic          load_acc, lbp_we, fetch, dump_hs, err_set;
    logic          border_q;
    logic [DW-1:0] gray_rd, lbp_rd;
    logic [DW-1:0] gray_q_unused, lbp_async_unused;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        load_acc = 1'b0;
        lbp_we   = 1'b0;
        fetch    = 1'b0;
        dump_hs  = dump_valid && dump_ready;
        case (state)
            LOAD: begin
                load_acc = load_valid;
                if (load_valid && ld_cnt == AW'(NPIX - 1)) state_nx = SERVE;
            end
            SERVE: begin
                lbp_we = lbp_valid;
                if (finish) state_nx = DUMP;
            end
            DUMP: begin
                // Prefetch whenever the output slot is empty or draining, until the last byte is out.
                fetch = (!dump_valid || dump_ready) && !(dump_valid && dump_last);
                if (dump_hs && dump_last) state_nx = DONE;
            end
            DONE: state_nx = DONE;
        endcase
    end

    assign wr_cnt_nx = (lbp_we && wr_cnt != '1) ? wr_cnt + 1'b1 : wr_cnt;

    // The finish check counts a write landing in the same cycle as finish.
    assign err_set = ((gray_req || lbp_valid) && state != SERVE)
                   || (lbp_valid && is_border(lbp_addr))
                   || (state == SERVE && finish && wr_cnt_nx != (AW+1)'(NINNER));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            ld_cnt     <= '0;
            wr_cnt     <= '0;
            dump_addr  <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            border_q   <= 1'b0;
            gray_ready <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_cnt     <= wr_cnt_nx;
            gray_ready <= (state_nx != LOAD);
            err        <= err | err_set;
            if (load_acc) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (fetch) begin
                dump_valid <= 1'b1;
                dump_last  <= (dump_addr == AW'(NPIX - 1));
                border_q   <= is_border(dump_addr);
                dump_addr  <= dump_addr + 1'b1;
            end else if (dump_hs) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end
        end
    end

    assign load_ready = (state == LOAD);
    assign gray_data  = (state == SERVE && gray_req) ? gray_rd : '0;
    assign dump_data  = border_q ? '0 : lbp_rd;

    lbp_dpram #(.DW(DW), .DEPTH(NPIX), .AW(AW)) gray_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (load_acc),
        .waddr  (ld_cnt),
        .wdata  (load_data),
        .araddr (gray_addr),
        .ardata (gray_rd),
        .re     (1'b0),
        .raddr  ('0),
        .rdata  (gray_q_unused)
    );

    lbp_dpram #(.DW(DW), .DEPTH(NPIX), .AW(AW)) lbp_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (lbp_we),
        .waddr  (lbp_addr),
        .wdata  (lbp_data),
        .araddr ('0),
        .ardata (lbp_async_unused),
        .re     (fetch),
        .raddr  (dump_addr),
        .rdata  (lbp_rd)
    );

endmodule

// File: doc/lbp_image_server.md
Name: lbp_image_server

Overview:
- Memory-side responder for the LBP gray/lbp interface; sits between the testbench/host loader and the LBP engine.
- Accepts a 128x128 8-bit gray image as a host byte stream and serves random gray reads to the engine.
- Captures LBP result writes, then streams the full 128x128 result image back to the host once the engine finishes.

Parameters:
- IMG_W, 128, image width in pixels (power of 2)
- IMG_H, 128, image height in pixels
- AW, 14, address width (log2(IMG_W*IMG_H))
- DW, 8, pixel width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- load_valid  in  1  host gray byte valid
- load_data  in  DW  host gray byte, raster order
- load_ready  out  1  server accepts load bytes
- gray_ready  out  1  image fully loaded; engine may start
- gray_req  in  1  engine read request
- gray_addr  in  AW  engine read address
- gray_data  out  DW  read data
- lbp_valid  in  1  engine result write strobe
- lbp_addr  in  AW  result address
- lbp_data  in  DW  result byte
- finish  in  1  engine done (level)
- dump_valid  out  1  result byte valid
- dump_data  out  DW  result byte, raster order
- dump_ready  in  1  host accepts result byte
- dump_last  out  1  marks final result byte (address IMG_W*IMG_H-1)
- err  out  1  sticky protocol error flag

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset state: LOAD, load_ready=1, gray_ready=0, gray_data=0, dump_valid=0, dump_data=0, dump_last=0, err=0, load/dump/write counters=0. Memory arrays are not cleared.
- FSM states: LOAD -> SERVE -> DUMP -> DONE.
- LOAD:
  - Each cycle with load_valid&load_ready writes gray_mem[ld_cnt] and increments ld_cnt.
  - On the accept of byte IMG_W*IMG_H-1, go to SERVE next cycle; load_ready=0 from that cycle.
- SERVE:
  - gray_ready=1 (registered, high from the first SERVE cycle).
  - gray_data = gray_mem[gray_addr] combinationally when gray_req=1, else 0. The engine samples it at the edge after it drives the address; there is zero-cycle read latency.
  - lbp_valid=1 writes lbp_mem[lbp_addr]=lbp_data at that edge and increments wr_cnt (AW+1 bits, saturating).
  - finish=1 moves the FSM to DUMP at the next edge.
  - If lbp_valid and finish are high in the same cycle, the write is performed, then the FSM goes to DUMP.
- DUMP:
  - Valid/ready stream of addresses 0..IMG_W*IMG_H-1.
  - dump_data is registered. For border addresses (row 0, row IMG_H-1, col 0, col IMG_W-1) it is forced to 0 regardless of memory contents; otherwise it is lbp_mem[addr].
  - dump_valid rises 1 cycle after DUMP entry.
  - Data is held stable while dump_valid&!dump_ready. The address advances only on handshake.
  - dump_last is asserted with the final byte. After the final handshake, go to DONE.
- DONE: dump_valid=0, gray_ready stays 1, and the FSM stays in DONE until reset.
- err (sticky) sets on any of:
  - gray_req=1 while not in SERVE
  - lbp_valid=1 while not in SERVE
  - lbp_valid on a border address
  - finish in SERVE with wr_cnt != (IMG_W-2)*(IMG_H-2) (=15876)
- A border-address write sets err and is still stored; dump masks it anyway.
- load_valid outside LOAD is ignored and does not set err.
- Reset in any state returns to LOAD; a new image must be fully reloaded.

Decomposition:
- Package lbp_pkg: IMG_W, IMG_H, AW, DW, NPIX=IMG_W*IMG_H, NINNER=(IMG_W-2)*(IMG_H-2), state enum {LOAD, SERVE, DUMP, DONE}, function is_border(addr) (row = addr[AW-1:log2 IMG_W], col = addr[log2 IMG_W-1:0]).
- One sub-module: lbp_dpram, a generic DW x NPIX RAM with synchronous write, an asynchronous read port (used for gray), and a registered read port (used for dump). It is instantiated twice: gray_mem and lbp_mem.

Test Plan:
- Load ramp: stream bytes addr[7:0] for 16384 cycles with load_valid=1 -> load_ready drops after the last byte; gray_ready=1 on the next cycle; gray_req=1 with gray_addr=129 gives gray_data=0x81 in the same cycle.
- Load backpressure: load_valid toggling 1/0 -> exactly 16384 bytes written; gray_ready rises only after the 16384th accept; a read of addr 16383 returns 0xFF.
- Full run with a reference LBP engine on a random image: 15876 writes then finish -> err=0; dumped bytes match the golden LBP image; borders=0; dump_last on byte 16383 only.
- Dump backpressure: dump_ready low for 3 cycles at address 200 -> dump_data held at lbp_mem[200]; no byte skipped or duplicated; total handshakes = 16384.
- Protocol errors: lbp_valid at addr 5 (row 0) -> err=1, and dump byte 5 = 0. Separately, finish after 100 writes -> err=1 while DUMP still proceeds.
- Reset mid-SERVE: assert reset while gray_req=1 -> gray_ready=0, gray_data=0, load_ready=1 immediately; after reload, gray_ready=1 again.
